// File: rtl/vga_pkg.sv
// Shared timing constants, axis phase encoding and colour type for the VGA frame sequencer.
package vga_pkg;

    localparam int CNT_W       = 10;

    localparam int H_SYNC_END  = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;

    localparam int V_SYNC_END  = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;

    typedef enum logic [1:0] {
        SYNC,
        BP,
        ACTIVE,
        FP
    } axis_state_t;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: position counter plus SYNC/BP/ACTIVE/FP phase machine, advanced by an enable.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int TOTAL     = 800,
    parameter int SYNC_END  = H_SYNC_END,
    parameter int ACT_START = H_ACT_START,
    parameter int ACT_END   = H_ACT_END
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_E  = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] ACT_S   = CNT_W'(ACT_START);
    localparam logic [CNT_W-1:0] ACT_E   = CNT_W'(ACT_END);

    logic [CNT_W-1:0] count_nxt;

    assign count_nxt = count + 1'b1;
    // High on the last position of the axis; the caller qualifies it with its own advance.
    assign wrap      = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= SYNC;
        end else if (adv) begin
            if (wrap) begin
                count <= '0;
                state <= SYNC;
            end else begin
                count <= count_nxt;
                case (state)
                    SYNC:    if (count_nxt == SYNC_E) state <= BP;
                    BP:      if (count_nxt == ACT_S)  state <= ACTIVE;
                    ACTIVE:  if (count_nxt == ACT_E)  state <= FP;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// 640x480@60 VGA sequencer: pixel-tick divider, H/V phase machines, registered sync/video/RGB
// decode and a frame-synchronous colour config slot. Optional border: define VGA_BORDER_EN.
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int DIV      = 4,
    parameter int HS_END   = H_SYNC_END,
    parameter int HA_START = H_ACT_START,
    parameter int HA_END   = H_ACT_END,
    parameter int VS_END   = V_SYNC_END,
    parameter int VA_START = V_ACT_START,
    parameter int VA_END   = V_ACT_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [11:0] cfg_color,
    output logic        cfg_ready,
    output logic        Hsynq,
    output logic        Vsynq,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start
);

    localparam int               DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] H_OFS    = CNT_W'(HA_START);
    localparam logic [CNT_W-1:0] V_OFS    = CNT_W'(VA_START);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HA_END - HA_START - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(VA_END - VA_START - 1);
`endif

    logic [DIV_W-1:0] div_cnt;
    logic             pix_tick;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    axis_state_t      h_state;
    axis_state_t      v_state;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap_p0;
    logic             active_win;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             pending_full;
    rgb12_t           pending_color;
    rgb12_t           active_color;
    rgb12_t           pix_color;

    assign pix_tick  = (div_cnt == DIV_LAST);
    assign cfg_ready = ~pending_full;

    always_ff @(posedge clk) begin
        if (reset || pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    vga_axis_fsm #(
        .TOTAL     (H_TOTAL),
        .SYNC_END  (HS_END),
        .ACT_START (HA_START),
        .ACT_END   (HA_END)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .adv   (pix_tick),
        .count (h_count),
        .state (h_state),
        .wrap  (h_wrap)
    );

    vga_axis_fsm #(
        .TOTAL     (V_TOTAL),
        .SYNC_END  (VS_END),
        .ACT_START (VA_START),
        .ACT_END   (VA_END)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .adv   (pix_tick & h_wrap),
        .count (v_count),
        .state (v_state),
        .wrap  (v_wrap)
    );

    assign active_win = (h_state == ACTIVE) && (v_state == ACTIVE);
    assign x_nxt      = active_win ? (h_count - H_OFS) : '0;
    assign y_nxt      = active_win ? (v_count - V_OFS) : '0;

    always_comb begin
        pix_color = active_color;
`ifdef VGA_BORDER_EN
        if (x_nxt == '0 || x_nxt == X_LAST || y_nxt == '0 || y_nxt == Y_LAST) begin
            pix_color = 12'hFFF;
        end
`endif
        if (!active_win) begin
            pix_color = '0;
        end
    end

    // Stage p0 -> outputs: every output is a one-clk-late decode of the counter/phase state.
    always_ff @(posedge clk) begin
        if (reset) begin
            Hsynq          <= 1'b1;
            Vsynq          <= 1'b1;
            video_on       <= 1'b0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            {Blue, Green, Red} <= '0;
            frame_wrap_p0  <= 1'b0;
            frame_start    <= 1'b0;
            pending_full   <= 1'b0;
            active_color   <= '0;
        end else begin
            Hsynq          <= (h_state != SYNC);
            Vsynq          <= (v_state != SYNC);
            video_on       <= active_win;
            pixel_x        <= x_nxt;
            pixel_y        <= y_nxt;
            {Blue, Green, Red} <= pix_color;
            frame_wrap_p0  <= pix_tick & h_wrap & v_wrap;
            frame_start    <= frame_wrap_p0;
            // Swap happens on the frame_start edge; a transfer on that same edge waits a frame.
            if (frame_wrap_p0 && pending_full) begin
                active_color <= pending_color;
                pending_full <= 1'b0;
            end
            if (cfg_valid && !pending_full) begin
                pending_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_valid && !pending_full) begin
            pending_color <= cfg_color;
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer on a shrunken timing grid (16x12 ticks, DIV 4).
module tb_vga_frame_sequencer;

    localparam int H_T  = 16;
    localparam int V_T  = 12;
    localparam int DV   = 4;
    localparam int H_SE = 4;
    localparam int H_AS = 6;
    localparam int H_AE = 14;
    localparam int V_SE = 2;
    localparam int V_AS = 4;
    localparam int V_AE = 10;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic [11:0] cfg_color;
    logic        cfg_ready;
    logic        Hsynq;
    logic        Vsynq;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] exp_q[$];
    logic [36:0] got_v;

    vga_frame_sequencer #(
        .H_TOTAL  (H_T),
        .V_TOTAL  (V_T),
        .DIV      (DV),
        .HS_END   (H_SE),
        .HA_START (H_AS),
        .HA_END   (H_AE),
        .VS_END   (V_SE),
        .VA_START (V_AS),
        .VA_END   (V_AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_color   (cfg_color),
        .cfg_ready   (cfg_ready),
        .Hsynq       (Hsynq),
        .Vsynq       (Vsynq),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got_v = {Hsynq, Vsynq, video_on, pixel_x, pixel_y, frame_start, cfg_ready,
                    Blue, Green, Red};

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: evaluated at each active edge from its own state, result queued.
    int          m_div, m_h, m_v;
    bit          m_fw, m_pf, m_tick, m_fw_n, m_nf, m_von;
    logic [11:0] m_pend, m_act, m_col;
    logic [9:0]  m_px, m_py;
    logic [36:0] m_exp;

    initial begin
        m_div = 0; m_h = 0; m_v = 0; m_fw = 0; m_pf = 0; m_pend = '0; m_act = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_exp = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 12'h000};
                m_div = 0; m_h = 0; m_v = 0; m_fw = 0; m_pf = 0; m_act = '0;
            end else begin
                m_von = (m_h >= H_AS && m_h < H_AE) && (m_v >= V_AS && m_v < V_AE);
                m_px  = m_von ? 10'(m_h - H_AS) : 10'd0;
                m_py  = m_von ? 10'(m_v - V_AS) : 10'd0;
                m_col = m_von ? m_act : 12'h000;
`ifdef VGA_BORDER_EN
                if (m_von && (m_px == 0 || m_px == 10'(H_AE - H_AS - 1) ||
                              m_py == 0 || m_py == 10'(V_AE - V_AS - 1)))
                    m_col = 12'hFFF;
`endif
                m_nf = m_pf;
                if (m_fw && m_pf) begin
                    m_act = m_pend;
                    m_nf  = 1'b0;
                end
                if (cfg_valid && !m_pf) begin
                    m_pend = cfg_color;
                    m_nf   = 1'b1;
                end
                m_exp = {!(m_h < H_SE), !(m_v < V_SE), m_von, m_px, m_py, m_fw, !m_nf, m_col};
                m_pf  = m_nf;
                m_tick = (m_div == DV - 1);
                m_fw_n = m_tick && (m_h == H_T - 1) && (m_v == V_T - 1);
                m_div  = m_tick ? 0 : m_div + 1;
                if (m_tick) begin
                    if (m_h == H_T - 1) begin
                        m_h = 0;
                        m_v = (m_v == V_T - 1) ? 0 : m_v + 1;
                    end else begin
                        m_h = m_h + 1;
                    end
                end
                m_fw = m_fw_n;
            end
            exp_q.push_back(m_exp);
        end
    end

    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("cycle", 40'(got_v), 40'(e));
            end
        end
    end

    task automatic wait_fs(input int budget, output int cyc, output int von, output int new_col);
        cyc = 0; von = 0; new_col = 0;
        do begin
            @(negedge clk);
            cyc = cyc + 1;
            if (video_on) von = von + 1;
            if ({Blue, Green, Red} == 12'h0F0) new_col = new_col + 1;
        end while (!frame_start && cyc < budget);
        if (!frame_start) check_eq("fs_timeout", 40'd0, 40'd1);
    endtask

    task automatic wait_von(input int ylim, input int budget);
        int n;
        n = 0;
        while (!(video_on && (ylim < 0 || int'(pixel_y) == ylim)) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= budget) check_eq("von_timeout", 40'd0, 40'd1);
    endtask

    localparam logic [11:0] FIRST_PIX_00A =
`ifdef VGA_BORDER_EN
        12'hFFF;
`else
        12'h00A;
`endif
    localparam logic [11:0] FIRST_PIX_CLR =
`ifdef VGA_BORDER_EN
        12'hFFF;
`else
        12'h000;
`endif

    initial begin
        int  cnt, cyc, von, ncol;
        bit  seen;
        reset = 1'b1; cfg_valid = 1'b0; cfg_color = 12'h000;
        repeat (10) @(negedge clk);
        check_eq("rst_hsync", 40'(Hsynq), 40'd1);
        check_eq("rst_ready", 40'(cfg_ready), 40'd1);
        reset = 1'b0;

        cnt = 0;
        while (Hsynq && cnt < 100) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (!Hsynq && cnt < 1000) begin @(negedge clk); cnt++; end
        check_eq("hsync_low", 40'(cnt), 40'(DV * H_SE));
        while (Hsynq && cnt < 2000) begin @(negedge clk); cnt++; end
        check_eq("line_period", 40'(cnt), 40'(DV * H_T));

        wait_fs(2000, cyc, von, ncol);
        wait_fs(2000, cyc, von, ncol);
        check_eq("frame_period", 40'(cyc), 40'(DV * H_T * V_T));
        check_eq("video_slots", 40'(von), 40'(DV * (H_AE - H_AS) * (V_AE - V_AS)));

        // Mid-frame colour update; a second request while full must be dropped.
        repeat (100) @(negedge clk);
        cfg_valid = 1'b1; cfg_color = 12'h0F0;
        @(negedge clk);
        check_eq("ready_low", 40'(cfg_ready), 40'd0);
        cfg_color = 12'h00F;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0;
        wait_fs(2000, cyc, von, ncol);
        check_eq("no_early_color", 40'(ncol), 40'd0);
        check_eq("ready_after_fs", 40'(cfg_ready), 40'd1);

        // Request lands on the very edge that asserts frame_start.
        seen = 1'b0;
        for (int i = 0; i < DV * H_T * V_T - 1; i++) begin
            @(negedge clk);
            if (!seen && video_on) begin
                check_eq("green_new", 40'(Green), 40'hF);
                seen = 1'b1;
            end
        end
        cfg_valid = 1'b1; cfg_color = 12'h00A;
        @(negedge clk);
        cfg_valid = 1'b0;
        check_eq("fs_same_edge", 40'(frame_start), 40'd1);
        check_eq("held_pending", 40'(cfg_ready), 40'd0);
        wait_fs(2000, cyc, von, ncol);
        check_eq("ready_next_fs", 40'(cfg_ready), 40'd1);
        wait_von(-1, 2000);
        check_eq("first_pix_00a", 40'({Blue, Green, Red}), 40'(FIRST_PIX_00A));

        // Reset mid-frame with a colour pending.
        cfg_valid = 1'b1; cfg_color = 12'h123;
        @(negedge clk);
        cfg_valid = 1'b0;
        check_eq("pend_123", 40'(cfg_ready), 40'd0);
        wait_von(2, 2000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("midrst_ready", 40'(cfg_ready), 40'd1);
        check_eq("midrst_von", 40'(video_on), 40'd0);
        reset = 1'b0;
        wait_fs(2000, cyc, von, ncol);
        wait_von(-1, 2000);
        check_eq("color_cleared", 40'({Blue, Green, Red}), 40'(FIRST_PIX_CLR));

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
